// File: rtl/iter_mul_div_if.sv
// Request/response bundle between the pipeline control and the iterative multiply/divide unit.
// The master drives the operands and the start request. The slave returns status and the register-file write port.
interface iter_mul_div_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          start;
    logic [1:0]    op;
    logic [DW-1:0] src_a;
    logic [DW-1:0] src_b;
    logic [AW-1:0] dst;
    logic          busy;
    logic          done;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    modport master (
        output start, op, src_a, src_b, dst,
        input  busy, done, rf_wen, rf_waddr, rf_wdata
    );

    modport slave (
        input  start, op, src_a, src_b, dst,
        output busy, done, rf_wen, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/iter_mul_div.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU unit that retires one bit per cycle.
// The result is written back through a dedicated register-file write port.
module iter_mul_div #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    iter_mul_div_if.slave     bus
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            done_q;
    logic            rf_wen_q;
    logic [AW-1:0]   rf_waddr_q;
    logic [DW-1:0]   rf_wdata_q;

    op_e             op_q;
    logic [AW-1:0]   dst_q;
    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic [2*DW-1:0] prod_q, prod_d;
    logic [DW:0]     rem_q, rem_d;
    logic [DW-1:0]   quo_q, quo_d;

    logic [DW:0]     prod_sum;
    logic [DW+1:0]   rem_shift;
    logic [DW+1:0]   rem_diff;
    logic [DW-1:0]   result_d;
    logic            div_by_zero;
    logic            last_iter;

    assign div_by_zero = bus.op[1] && (bus.src_b == '0);
    assign last_iter   = (cnt_q == CW'(DW - 1));

    // One iteration of both algorithms; op_q only selects which one is reported.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        prod_sum  = {1'b0, prod_q[2*DW-1:DW]} + {1'b0, a_q};
        prod_d    = prod_q[0] ? {prod_sum, prod_q[DW-1:1]} : {1'b0, prod_q[2*DW-1:1]};
        rem_shift = {rem_q, quo_q[DW-1]};
        rem_diff  = rem_shift - {2'b00, b_q};
        rem_d     = rem_shift[DW:0];
        quo_d     = {quo_q[DW-2:0], 1'b0};
        if (!rem_diff[DW+1]) begin
            rem_d = rem_diff[DW:0];
            quo_d = {quo_q[DW-2:0], 1'b1};
        end
        result_d = prod_d[DW-1:0];
        case (op_q)
            OP_MUL:   result_d = prod_d[DW-1:0];
            OP_MULHU: result_d = prod_d[2*DW-1:DW];
            OP_DIVU:  result_d = quo_d;
            OP_REMU:  result_d = rem_d[DW-1:0];
            default:  result_d = prod_d[DW-1:0];
        endcase
    end

    // NOTE: datapath registers carry no reset; they are only consumed while the FSM is in CALC.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.start) begin
            op_q   <= op_e'(bus.op);
            dst_q  <= bus.dst;
            a_q    <= bus.src_a;
            b_q    <= bus.src_b;
            prod_q <= {{DW{1'b0}}, bus.src_b};
            rem_q  <= '0;
            quo_q  <= bus.src_a;
        end else if (state_q == CALC) begin
            prod_q <= prod_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q   <= 1'b0;
                    rf_wen_q <= 1'b0;
                    if (bus.start) begin
                        cnt_q <= '0;
                        if (div_by_zero) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            rf_wen_q   <= (bus.dst != '0);
                            rf_waddr_q <= bus.dst;
                            rf_wdata_q <= bus.op[0] ? bus.src_a : '1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter) begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        rf_wen_q   <= (dst_q != '0);
                        rf_waddr_q <= dst_q;
                        rf_wdata_q <= result_d;
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    done_q   <= 1'b0;
                    rf_wen_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.rf_wen   = rf_wen_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
endmodule

// File: tb/tb_iter_mul_div.sv
// Directed bench for iter_mul_div using hand-computed results, latencies and handshake behaviour.
// Inputs change on the falling edge and outputs are sampled there, away from the active edge.
module tb_iter_mul_div;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    iter_mul_div_if #(.DW(32), .AW(5)) bus ();
    iter_mul_div #(.DW(32), .AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Launch one operation, then scramble the inputs to show that they were captured at the start edge.
    // Latency counts edges with the start edge as edge 1.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] dst, input logic [31:0] exp_res,
                          input int exp_edges, input logic exp_wen);
        int edges;
        int busy_cycles;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b; bus.dst = dst;
        @(posedge clk);
        edges = 1;
        busy_cycles = 0;
        @(negedge clk);
        bus.start = 1'b0; bus.op = ~op; bus.src_a = ~a; bus.src_b = ~b; bus.dst = ~dst;
        while (!bus.done && edges < 100) begin
            if (bus.busy) busy_cycles++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (bus.busy) busy_cycles++;
        check({tag, " latency"}, 64'(edges), 64'(exp_edges));
        check({tag, " busy_cycles"}, 64'(busy_cycles), 64'(exp_edges));
        check({tag, " done"}, 64'(bus.done), 64'd1);
        check({tag, " rf_wdata"}, 64'(bus.rf_wdata), 64'(exp_res));
        check({tag, " rf_waddr"}, 64'(bus.rf_waddr), 64'(dst));
        check({tag, " rf_wen"}, 64'(bus.rf_wen), 64'(exp_wen));
        @(posedge clk);
        @(negedge clk);
        check({tag, " done_drop"}, 64'(bus.done), 64'd0);
        check({tag, " wen_drop"}, 64'(bus.rf_wen), 64'd0);
        check({tag, " idle"}, 64'(bus.busy), 64'd0);
        check({tag, " wdata_hold"}, 64'(bus.rf_wdata), 64'(exp_res));
    endtask

    initial begin
        int done_pulses;
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0; bus.dst = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset rf_wen", 64'(bus.rf_wen), 64'd0);
        check("reset rf_waddr", 64'(bus.rf_waddr), 64'd0);
        check("reset rf_wdata", 64'(bus.rf_wdata), 64'd0);
        rst = 1'b0;

        // Basic products, full-width corner products and quotients.
        run_op("T1 mul 7*6",       2'b00, 32'd7,          32'd6,          5'd5,  32'd42,         33, 1'b1);
        run_op("T2 mul max*max",   2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0001,  33, 1'b1);
        run_op("T2 mulhu max*max", 2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,  33, 1'b1);
        run_op("mul lo 1234*16",   2'b00, 32'h1234_5678,  32'h0000_0010,  5'd3,  32'h2345_6780,  33, 1'b1);
        run_op("mulhu 2^31*4",     2'b01, 32'h8000_0000,  32'd4,          5'd4,  32'h0000_0002,  33, 1'b1);
        run_op("T3 divu 100/7",    2'b10, 32'd100,        32'd7,          5'd6,  32'd14,         33, 1'b1);
        run_op("T3 remu 100/7",    2'b11, 32'd100,        32'd7,          5'd7,  32'd2,          33, 1'b1);
        run_op("divu max/1",       2'b10, 32'hFFFF_FFFF,  32'd1,          5'd8,  32'hFFFF_FFFF,  33, 1'b1);
        run_op("divu max/max",     2'b10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd9,  32'd1,          33, 1'b1);
        run_op("remu fffe/max",    2'b11, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  5'd10, 32'hFFFF_FFFE,  33, 1'b1);
        run_op("remu 7/100",       2'b11, 32'd7,          32'd100,        5'd11, 32'd7,          33, 1'b1);

        // Divide by zero skips CALC: done appears right after the start edge and busy lasts one cycle.
        run_op("T4 divu 5/0",      2'b10, 32'd5,          32'd0,          5'd12, 32'hFFFF_FFFF,  1,  1'b1);
        run_op("T4 remu 5/0",      2'b11, 32'd5,          32'd0,          5'd13, 32'd5,          1,  1'b1);

        // A zero destination still pulses done but must not write.
        run_op("T5 mul dst0",      2'b00, 32'd7,          32'd6,          5'd0,  32'd42,         33, 1'b0);

        // Hold start high with new operands through CALC and DONE; only the original operation may retire.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.src_a = 32'd100; bus.src_b = 32'd7; bus.dst = 5'd9;
        @(posedge clk);
        @(negedge clk);
        bus.op = 2'b00; bus.src_a = 32'd2; bus.src_b = 32'd2; bus.dst = 5'd4;
        done_pulses = 0;
        for (int i = 0; i < 40 && !bus.done; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        if (bus.done) done_pulses++;
        check("T5 busy_start wdata", 64'(bus.rf_wdata), 64'd14);
        check("T5 busy_start waddr", 64'(bus.rf_waddr), 64'd9);
        check("T5 busy_start wen", 64'(bus.rf_wen), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("T5 idle after done", 64'(bus.busy), 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) done_pulses++;
        end
        check("T5 done pulses", 64'(done_pulses), 64'd1);
        check("T5 busy after window", 64'(bus.busy), 64'd0);

        // Reset during iteration 10 of a DIVU abandons it without a write.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.src_a = 32'd1000; bus.src_b = 32'd3; bus.dst = 5'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("T6 busy before rst", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("T6 rst busy", 64'(bus.busy), 64'd0);
        check("T6 rst done", 64'(bus.done), 64'd0);
        check("T6 rst wen", 64'(bus.rf_wen), 64'd0);
        check("T6 rst waddr", 64'(bus.rf_waddr), 64'd0);
        check("T6 rst wdata", 64'(bus.rf_wdata), 64'd0);
        rst = 1'b0;
        done_pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done || bus.rf_wen) done_pulses++;
        end
        check("T6 no write after rst", 64'(done_pulses), 64'd0);
        run_op("T6 mul 3*4",       2'b00, 32'd3,          32'd4,          5'd2,  32'd12,         33, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
